// File: rtl/weverest_pkg.sv
// rtl/weverest_pkg.sv - shared types and constants for the square-root display block
package weverest_pkg;

  localparam int X_W = 6;
  localparam int R_W = 3;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    ITER0   = 3'd1,
    ITER1   = 3'd2,
    ITER2   = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is 1.
  localparam logic [6:0] SEG7 [0:7] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
  };

endpackage

// File: rtl/weverest_sqrt_seg7.sv
// rtl/weverest_sqrt_seg7.sv - combinational root digit to seven-segment decoder
module sqrt_seg7
  import weverest_pkg::*;
(
  input  logic [R_W-1:0] digit,
  output logic [6:0]     seg
);

  assign seg = SEG7[digit];

endmodule

// File: rtl/weverest_top.sv
// rtl/weverest_top.sv - pad wrapper with a digit-by-digit integer square root engine
module weverest_top
  import weverest_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire        vccd1,
  inout  wire        vssd1,
`endif
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic           clk;
  logic           rst_n;
  logic [X_W-1:0] x;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign x     = io_in[7:2];

  state_t state, state_nx;
  logic   do_load, do_iter, do_publish;

  logic [X_W-1:0] rad;
  logic [X_W-1:0] rem;
  logic [R_W-1:0] root;

  logic [X_W-1:0] rem_sh;
  logic [4:0]     trial;
  logic           fits;
  logic [6:0]     seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = LOAD;
    case (state)
      LOAD:    state_nx = ITER0;
      ITER0:   state_nx = ITER1;
      ITER1:   state_nx = ITER2;
      ITER2:   state_nx = PUBLISH;
      PUBLISH: state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    do_load    = 1'b0;
    do_iter    = 1'b0;
    do_publish = 1'b0;
    case (state)
      LOAD:                do_load    = 1'b1;
      ITER0, ITER1, ITER2: do_iter    = 1'b1;
      PUBLISH:             do_publish = 1'b1;
      default:             do_load    = 1'b0;
    endcase
  end

  // rad shifts left each iteration so the next bit pair is always rad[5:4].
  assign rem_sh = (rem << 2) | {4'b0000, rad[5:4]};
  assign trial  = {root, 2'b01};
  assign fits   = rem_sh >= {1'b0, trial};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
    end else if (do_load) begin
      rad  <= x;
      rem  <= '0;
      root <= '0;
    end else if (do_iter) begin
      rad <= {rad[3:0], 2'b00};
      if (fits) begin
        rem  <= rem_sh - {1'b0, trial};
        root <= {root[1:0], 1'b1};
      end else begin
        rem  <= rem_sh;
        root <= {root[1:0], 1'b0};
      end
    end
  end

  sqrt_seg7 u_seg (
    .digit (root),
    .seg   (seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          io_out <= 8'h00;
    else if (do_publish) io_out <= {1'b1, seg};
  end

endmodule

// File: tb/tb_weverest_top.sv
// tb/tb_weverest_top.sv - scoreboard bench for the square-root display wrapper
module tb_weverest_top;

  logic       clk = 1'b0;
  logic [6:0] hi  = 7'h01;
  logic [7:0] io_in;
  logic [7:0] io_out;
`ifdef USE_POWER_PINS
  wire vccd1 = 1'b1;
  wire vssd1 = 1'b0;
`endif

  assign io_in = {hi, clk};

  weverest_top dut (
`ifdef USE_POWER_PINS
    .vccd1  (vccd1),
    .vssd1  (vssd1),
`endif
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  function automatic logic [7:0] model(input int xv);
    logic [6:0] tbl [0:7];
    int r;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    r = 0;
    while ((r + 1) * (r + 1) <= xv) r++;
    return {1'b1, tbl[r]};
  endfunction

  task automatic pop_exp();
    if (exp_q.size() == 0) exp_v = 8'hxx;
    else exp_v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    #1 hi = 7'h00;
    #1;
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: got %h want 00", io_out);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (io_out !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold%0d: got %h want 00", i, io_out);
      end
    end
  endtask

  task automatic test_first();
    hi = 7'h01;
    exp_q.push_back(model(0));
    for (int i = 1; i <= 4; i++) @(negedge clk);
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL first_edge4: got %h want 00", io_out);
    end
    @(negedge clk);
    pop_exp();
    total++;
    if (io_out !== exp_v) begin
      bad++;
      $display("FAIL first_edge5: got %h want %h", io_out, exp_v);
    end
  endtask

  task automatic test_max();
    bit seen;
    hi = {6'd63, 1'b1};
    exp_q.push_back(model(63));
    pop_exp();
    seen = 1'b0;
    for (int i = 0; i < 9 && !seen; i++) begin
      @(negedge clk);
      if (io_out === exp_v) seen = 1'b1;
    end
    total++;
    if (io_out !== exp_v) begin
      bad++;
      $display("FAIL max_latency9: got %h want %h", io_out, exp_v);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (io_out !== exp_v) begin
        bad++;
        $display("FAIL max_hold%0d: got %h want %h", i, io_out, exp_v);
      end
    end
  endtask

  task automatic test_sweep();
    int xs [4] = '{15, 16, 48, 49};
    for (int k = 0; k < 4; k++) begin
      hi = {xs[k][5:0], 1'b1};
      exp_q.push_back(model(xs[k]));
      for (int i = 0; i < 10; i++) @(negedge clk);
      pop_exp();
      total++;
      if (io_out !== exp_v) begin
        bad++;
        $display("FAIL sweep_x%0d: got %h want %h", xs[k], io_out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      hi = 7'd32;
      #1;
      total++;
      if (io_out !== 8'h00) begin
        bad++;
        $display("FAIL toggle_reset%0d: got %h want 00", n, io_out);
      end
      for (int i = 0; i < 5; i++) @(negedge clk);
      hi = 7'd127;
      exp_q.push_back(model(63));
      for (int i = 0; i < 5; i++) @(negedge clk);
      pop_exp();
      total++;
      if (io_out !== exp_v) begin
        bad++;
        $display("FAIL toggle_run%0d: got %h want %h", n, io_out, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    hi = 7'h00;
    @(negedge clk);
    hi = {6'd63, 1'b1};
    for (int i = 0; i < 5; i++) @(negedge clk);
    total++;
    if (io_out !== model(63)) begin
      bad++;
      $display("FAIL mid_pre: got %h want %h", io_out, model(63));
    end
    // two more edges execute LOAD and ITER0, leaving the FSM in ITER1
    @(negedge clk);
    @(negedge clk);
    #2 hi = {6'd16, 1'b0};
    #1;
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_abort: got %h want 00", io_out);
    end
    @(negedge clk);
    hi = {6'd16, 1'b1};
    exp_q.push_back(model(16));
    for (int i = 0; i < 4; i++) @(negedge clk);
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_edge4: got %h want 00", io_out);
    end
    @(negedge clk);
    pop_exp();
    total++;
    if (io_out !== exp_v) begin
      bad++;
      $display("FAIL mid_edge5: got %h want %h", io_out, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_max();
    test_sweep();
    test_back_to_back();
    test_mid_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weverest_top.md
# weverest_top

Tiny-tapeout style top wrapper that computes the integer square root of a 6-bit operand and shows the 3-bit result on a seven-segment display. It sits directly on the 8-bit `io_in`/`io_out` scan-chain pads. It must survive synthesis to a gate-level netlist with explicit power pins. The clock is slow, nominally 1 kHz, and the design is a small sequential digit-by-digit root engine.

## Interface
- No parameters.
- `io_in[0]`  in  1  clock `clk`; all state updates on the rising edge.
- `io_in[1]`  in  1  reset `rst_n`; asynchronous, active-low.
- `vccd1`  inout  1  power pin; gate-level netlist only (USE_POWER_PINS).
- `vssd1`  inout  1  ground pin; gate-level netlist only.
- `io_in[7:2]`  in  6  operand `x`, unsigned 0..63, sampled once per computation.
- `io_out[6:0]`  out  7  seven-segment code of the root: bit0 = segment a … bit6 = segment g; a lit segment drives 1.
- `io_out[7]`  out  1  `valid`; 1 once at least one result has been published since reset.

## Operation
- The result is `r = floor(sqrt(x))`, range 0..7.
- The FSM free-runs through LOAD → ITER0 → ITER1 → ITER2 → PUBLISH → LOAD, with no idle state.
- **LOAD**
  - Sample `x` into `rad[5:0]`.
  - Clear `rem[5:0]` and `root[2:0]`.
- **ITERk** (k = 0..2, consuming radicand bit pairs from the MSB down):
  - `rem = (rem << 2) | next pair`.
  - `trial = (root << 2) | 1`, 5 bits wide.
  - If `rem >= trial`: `rem -= trial`, `root = (root << 1) | 1`.
  - Otherwise: `root = root << 1`.
  - All arithmetic is unsigned; `rem` never exceeds 63, so there is no overflow.
- **PUBLISH**
  - Register `io_out[6:0] = seg(root)` and set `valid`.
  - Segment codes: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07.
- Outputs are fully registered and hold their value between PUBLISH states.
- A change on `io_in[7:2]` after LOAD does not affect the computation in flight; it is picked up at the next LOAD.

## Timing
- **During reset**
  - `io_out` = 0x00 (blank, `valid` = 0).
  - FSM in LOAD; `rad`, `rem`, `root` cleared.
- Reset assertion takes effect immediately and asynchronously. Reset mid-computation abandons it; `io_out` goes to 0x00.
- **After reset release**
  - The 1st rising edge executes LOAD.
  - The 5th rising edge executes PUBLISH, so `io_out` updates after the 5th edge.
- Throughput: one result per 5 clocks.
- Latency from the LOAD edge to the updated `io_out`: 4 clocks.
- Worst-case latency from an input change to a display of its root: 9 clocks.

## Structure
- **Package `weverest_pkg`:**
  - State enum: LOAD, ITER0, ITER1, ITER2, PUBLISH.
  - Seven-segment constant array `SEG7[0:7]`.
  - Width constants: `X_W = 6`, `R_W = 3`.
- **Sub-module `sqrt_seg7`:** purely combinational 3-bit → 7-segment decoder.
- **Top:** pad mapping, FSM, datapath registers, output register.

## Test plan
- Hold `io_in = 0x00` (reset asserted) → `io_out` stays 0x00 on every edge.
- Release with `x = 0` (`io_in = 0x02`) → after the 5th edge `io_out = 0xBF`.
- Apply `io_in = 0xFE` (`x = 63`) → after ≤ 9 edges `io_out = 0x87`, and it stays 0x87 while held.
- Sweep `x` = 15, 16, 48, 49 → `io_out` = 0xCF, 0xE6, 0xFD, 0x87 respectively.
- Alternate `io_in[7:1]` between 32 and 127 every 5 negedges:
  - 32 holds `rst_n` low → `io_out` forced to 0x00 asynchronously.
  - 127 releases reset with `x = 63` → 0x87 appears 5 edges later.
- Assert `rst_n` during ITER1, then release → `io_out` = 0x00 immediately; a fresh 5-clock computation follows.
